// File: rtl/w_order_scheduler.sv
// W-channel scheduler: routes master W bursts onto the slave W FIFO strictly
// in AW acceptance order, using a small queue of {master, len} entries.
module w_order_scheduler #(
    parameter int unsigned masters       = 2,
    parameter int unsigned pending_depth = 8,
    parameter int unsigned LEN_WIDTH     = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        aw_push,
    input  logic [$clog2(masters)-1:0]  aw_master,
    input  logic [LEN_WIDTH-1:0]        aw_len,
    output logic                        order_full,
    input  logic [masters-1:0]          master_w_valid,
    input  logic [masters-1:0]          master_w_last,
    input  logic                        slave_w_full,
    output logic                        w_push,
    output logic [masters-1:0]          w_pop_master,
    output logic [$clog2(masters)-1:0]  w_src_master,
    output logic                        w_active,
    output logic                        len_error
);

    localparam int unsigned MW = $clog2(masters);
    localparam int unsigned PW = $clog2(pending_depth);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          cur_master_q, cur_master_d;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [MW-1:0]          q_master_mem [pending_depth];
    logic [LEN_WIDTH-1:0]   q_len_mem    [pending_depth];
    logic                   len_error_q;

    logic q_empty;
    logic push_ok;
    logic pop;
    logic xfer;
    logic last_beat;

    assign q_empty    = (count_q == '0);
    assign order_full = (count_q == CW'(pending_depth));
    assign push_ok    = aw_push & ~order_full & ~ARESET;
    assign last_beat  = (beat_cnt_q == '0);
    // Reset gates the transfer so nothing is pushed or popped in the reset cycle.
    assign xfer       = (state_q == BURST) & master_w_valid[cur_master_q]
                        & ~slave_w_full & ~ARESET;

    // Order queue pointers and occupancy.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) begin
            q_master_mem[wr_ptr_q] <= aw_master;
            q_len_mem[wr_ptr_q]    <= aw_len;
        end
    end

    // Scheduler state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            cur_master_q <= '0;
            beat_cnt_q   <= '0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_master_q <= cur_master_d;
            beat_cnt_q   <= beat_cnt_d;
            len_error_q  <= xfer & (master_w_last[cur_master_q] != last_beat);
        end
    end

    // Next state; the last beat reloads from the queue head without a bubble.
    always_comb begin
        state_d      = state_q;
        cur_master_d = cur_master_q;
        beat_cnt_d   = beat_cnt_q;
        pop          = 1'b0;
        w_push       = 1'b0;
        w_pop_master = '0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop          = 1'b1;
                    cur_master_d = q_master_mem[rd_ptr_q];
                    beat_cnt_d   = q_len_mem[rd_ptr_q];
                    state_d      = BURST;
                end
            end
            BURST: begin
                w_push = xfer;
                if (xfer) begin
                    w_pop_master = masters'(1) << cur_master_q;
                    if (!last_beat) begin
                        beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
                    end else if (!q_empty) begin
                        pop          = 1'b1;
                        cur_master_d = q_master_mem[rd_ptr_q];
                        beat_cnt_d   = q_len_mem[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_src_master = cur_master_q;
    assign w_active     = (state_q == BURST);
    assign len_error    = len_error_q;

endmodule

// File: tb/tb_w_order_scheduler.sv
// Bench for w_order_scheduler: AW-order queue model checked every cycle, plus
// directed scenarios with hand-computed push counts, timing and sources.
module tb_w_order_scheduler;

    localparam int unsigned M  = 2;
    localparam int unsigned D  = 8;
    localparam int unsigned LW = 4;

    logic          ACLK;
    logic          ARESET;
    logic          aw_push;
    logic [0:0]    aw_master;
    logic [LW-1:0] aw_len;
    logic          order_full;
    logic [M-1:0]  master_w_valid;
    logic [M-1:0]  master_w_last;
    logic          slave_w_full;
    logic          w_push;
    logic [M-1:0]  w_pop_master;
    logic [0:0]    w_src_master;
    logic          w_active;
    logic          len_error;

    w_order_scheduler #(.masters(M), .pending_depth(D), .LEN_WIDTH(LW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .aw_push(aw_push), .aw_master(aw_master),
        .aw_len(aw_len), .order_full(order_full), .master_w_valid(master_w_valid),
        .master_w_last(master_w_last), .slave_w_full(slave_w_full), .w_push(w_push),
        .w_pop_master(w_pop_master), .w_src_master(w_src_master),
        .w_active(w_active), .len_error(len_error)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {int m; int len;} ent_t;

    ent_t mq[$];
    bit   src0[$];
    bit   src1[$];
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   push_log[$];
    int   src_log[$];
    int   err_pulses = 0;
    logic [M-1:0] pop_pending = '0;

    // Model: pending AWs in order, the burst in flight and its beats remaining.
    bit   m_active = 0;
    int   m_cur = 0;
    int   m_rem = 0;
    bit   m_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    always @(negedge ACLK) begin : cmp
        int   ep;
        int   epop;
        logic v;
        logic l;
        bit   nerr;
        int   sz;
        ent_t e;
        ncyc++;
        v    = master_w_valid[m_cur];
        l    = master_w_last[m_cur];
        ep   = (!ARESET && m_active && v && !slave_w_full) ? 1 : 0;
        epop = (ep != 0) ? (1 << m_cur) : 0;
        chk("w_push", int'(w_push), ep);
        chk("w_pop_master", int'(w_pop_master), epop);
        chk("w_src_master", int'(w_src_master), m_cur);
        chk("w_active", int'(w_active), int'(m_active));
        chk("len_error", int'(len_error), int'(m_err));
        chk("order_full", int'(order_full), (mq.size() == D) ? 1 : 0);
        if (w_push) begin
            push_log.push_back(ncyc);
            src_log.push_back(int'(w_src_master));
        end
        if (len_error) err_pulses++;
        pop_pending = w_pop_master;
        if (ARESET) begin
            mq.delete();
            m_active = 0;
            m_cur    = 0;
            m_rem    = 0;
            m_err    = 0;
        end else begin
            sz   = mq.size();
            nerr = (ep != 0) && (l != (m_rem == 1));
            if (m_active) begin
                if (ep != 0) begin
                    if (m_rem == 1) begin
                        if (sz > 0) begin
                            e = mq.pop_front();
                            m_cur = e.m;
                            m_rem = e.len + 1;
                        end else begin
                            m_active = 0;
                        end
                    end else begin
                        m_rem--;
                    end
                end
            end else if (sz > 0) begin
                e = mq.pop_front();
                m_cur    = e.m;
                m_rem    = e.len + 1;
                m_active = 1;
            end
            if (aw_push && sz < D) begin
                e.m   = int'(aw_master);
                e.len = int'(aw_len);
                mq.push_back(e);
            end
            m_err = nerr;
        end
    end

    task automatic refresh();
        master_w_valid = {src1.size() != 0, src0.size() != 0};
        master_w_last  = {(src1.size() != 0) ? src1[0] : 1'b0,
                          (src0.size() != 0) ? src0[0] : 1'b0};
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
        if (pop_pending[0] && src0.size() > 0) void'(src0.pop_front());
        if (pop_pending[1] && src1.size() > 0) void'(src1.pop_front());
        refresh();
    endtask

    task automatic load(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            if (m == 0) src0.push_back(i == n - 1);
            else        src1.push_back(i == n - 1);
        end
        refresh();
    endtask

    task automatic aw(input int m, input int len, output int c);
        c         = ncyc + 1;
        aw_push   = 1'b1;
        aw_master = 1'(m);
        aw_len    = LW'(len);
        cyc();
        aw_push   = 1'b0;
    endtask

    task automatic clr();
        push_log.delete();
        src_log.delete();
        err_pulses = 0;
    endtask

    task automatic do_reset();
        ARESET       = 1'b1;
        slave_w_full = 1'b0;
        src0.delete();
        src1.delete();
        refresh();
        cyc();
        cyc();
        ARESET = 1'b0;
        clr();
    endtask

    initial begin
        int c;
        ARESET         = 1'b1;
        aw_push        = 1'b0;
        aw_master      = '0;
        aw_len         = '0;
        slave_w_full   = 1'b0;
        master_w_valid = '0;
        master_w_last  = '0;
        do_reset();
        chk("rst_active", int'(w_active), 0);
        chk("rst_full", int'(order_full), 0);
        chk("rst_src", int'(w_src_master), 0);

        // Single 4-beat burst from master 1.
        load(1, 4);
        aw(1, 3, c);
        repeat (8) cyc();
        chk("s1_pushes", push_log.size(), 4);
        if (push_log.size() == 4) begin
            chk("s1_first_at", push_log[0] - c, 2);
            chk("s1_span", push_log[3] - push_log[0], 3);
            for (int i = 0; i < 4; i++) chk("s1_src", src_log[i], 1);
        end
        chk("s1_err", err_pulses, 0);
        chk("s1_idle", int'(w_active), 0);

        // Back-to-back bursts m0/len0, m1/len1, m0/len0.
        do_reset();
        load(0, 1); load(1, 2); load(0, 1);
        aw(0, 0, c); aw(1, 1, c); aw(0, 0, c);
        repeat (10) cyc();
        chk("s2_pushes", push_log.size(), 4);
        if (push_log.size() == 4) begin
            chk("s2_span", push_log[3] - push_log[0], 3);
            chk("s2_src0", src_log[0], 0);
            chk("s2_src1", src_log[1], 1);
            chk("s2_src2", src_log[2], 1);
            chk("s2_src3", src_log[3], 0);
        end

        // Fill the queue: first AW moves into the stalled burst, 8 more fill it.
        do_reset();
        for (int i = 0; i < 9; i++) aw(0, 0, c);
        chk("s3_full", int'(order_full), 1);
        aw(1, 0, c);
        chk("s3_full_after_drop", int'(order_full), 1);
        load(0, 1);
        cyc();
        chk("s3_not_full", int'(order_full), 0);
        for (int i = 0; i < 8; i++) load(0, 1);
        repeat (30) cyc();
        chk("s3_total_pushes", push_log.size(), 9);
        chk("s3_idle", int'(w_active), 0);

        // Slave backpressure for 3 cycles mid-burst.
        do_reset();
        load(0, 3);
        aw(0, 2, c);
        cyc();
        cyc();
        slave_w_full = 1'b1;
        repeat (3) cyc();
        slave_w_full = 1'b0;
        repeat (6) cyc();
        chk("s4_pushes", push_log.size(), 3);
        if (push_log.size() == 3) chk("s4_gap", push_log[1] - push_log[0], 4);
        chk("s4_idle", int'(w_active), 0);

        // Early WLAST on a 2-beat burst.
        do_reset();
        src1.push_back(1'b1);
        src1.push_back(1'b1);
        refresh();
        aw(1, 1, c);
        repeat (8) cyc();
        chk("s5_err_pulses", err_pulses, 1);
        chk("s5_pushes", push_log.size(), 2);

        // Reset mid-burst with three entries queued.
        do_reset();
        load(0, 5);
        aw(0, 4, c); aw(1, 0, c); aw(1, 0, c); aw(1, 0, c);
        chk("s6_mid_active", int'(w_active), 1);
        ARESET = 1'b1;
        cyc();
        chk("s6_rst_active", int'(w_active), 0);
        chk("s6_rst_push", int'(w_push), 0);
        chk("s6_rst_full", int'(order_full), 0);
        ARESET = 1'b0;
        clr();
        repeat (6) cyc();
        chk("s6_no_push", push_log.size(), 0);
        chk("s6_idle", int'(w_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
